// File: rtl/req_ack_32bit_receiver_if.sv
// req_ack_32bit_receiver_if: link-side request/acknowledge and core-side valid/ready signals of the frame receiver
interface req_ack_32bit_receiver_if #(parameter int DEPTH_LOG2 = 2);
  logic                request;
  logic [31:0]         din;
  logic                acknowledge;
  logic [63:0]         dout;
  logic                valid;
  logic                ready;
  logic [DEPTH_LOG2:0] level;
  modport slave (input request, din, ready, output acknowledge, dout, valid, level);
  modport master (output request, din, ready, input acknowledge, dout, valid, level);
endinterface

// File: rtl/req_ack_32bit_receiver.sv
// req_ack_32bit_receiver: 2-phase req/ack link receiver pairing 32-bit words into 64-bit frames in a FWFT FIFO.
// Optional macro RX_FRAME_CNT_EN adds a 32-bit count of pushed frames.
module req_ack_32bit_receiver #(parameter int DEPTH_LOG2 = 2) (
  input  logic clk,
  input  logic rstn,
  req_ack_32bit_receiver_if.slave bus
`ifdef RX_FRAME_CNT_EN
  ,
  output logic [31:0] frame_cnt
`endif
);
  localparam int PW = DEPTH_LOG2 + 1;
  logic          req_syn1_q, req_syn2_q, req_q;
  logic          pend_q, pend_d;
  logic          word_part_q, word_part_d;
  logic          ack_q, ack_d;
  logic [31:0]   hi_buf_q, hi_buf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [2**DEPTH_LOG2];
  logic          req_pulse, pend_eff, full, empty, pop, push_ok, consume, push;
  always_comb begin
    req_pulse   = req_syn2_q ^ req_q;
    pend_eff    = req_pulse | pend_q;
    empty       = wr_ptr_q == rd_ptr_q;
    full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    pop         = !empty & bus.ready;
    push_ok     = !full | pop;
    // the high word never needs FIFO room; only the low word waits on it
    consume     = pend_eff & (!word_part_q | push_ok);
    push        = consume & word_part_q;
    pend_d      = pend_eff & !consume;
    ack_d       = ack_q ^ consume;
    word_part_d = word_part_q ^ consume;
    hi_buf_d    = (consume & !word_part_q) ? bus.din : hi_buf_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_syn1_q  <= 1'b0;
      req_syn2_q  <= 1'b0;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      word_part_q <= 1'b0;
      ack_q       <= 1'b0;
      hi_buf_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem_q[i] <= '0;
    end else begin
      req_syn1_q  <= bus.request;
      req_syn2_q  <= req_syn1_q;
      req_q       <= req_syn2_q;
      pend_q      <= pend_d;
      word_part_q <= word_part_d;
      ack_q       <= ack_d;
      hi_buf_q    <= hi_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[PW-2:0]] <= {hi_buf_q, bus.din};
    end
  end
`ifdef RX_FRAME_CNT_EN
  logic [31:0] frame_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_cnt_q <= '0;
    else if (push) frame_cnt_q <= frame_cnt_q + 32'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif
  assign bus.acknowledge = ack_q;
  assign bus.valid       = !empty;
  assign bus.dout        = mem_q[rd_ptr_q[PW-2:0]];
  assign bus.level       = wr_ptr_q - rd_ptr_q;
endmodule
